// File: rtl/lcd_win_pkg.sv
// +----------------------------------------------------------------------------+
// | lcd_win_pkg : shared types and sizing helpers for the LCD window controller |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package lcd_win_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD     = 3'd0,
    CMD_ZOOM_IN  = 3'd1,
    CMD_ZOOM_FIT = 3'd2,
    CMD_RIGHT    = 3'd3,
    CMD_LEFT     = 3'd4,
    CMD_UP       = 3'd5,
    CMD_DOWN     = 3'd6,
    CMD_REFRESH  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  typedef enum logic {
    VM_FIT  = 1'b0,
    VM_ZOOM = 1'b1
  } view_mode_e;

  function automatic int fsx_f(input int img_w, input int win);
    return img_w / win;
  endfunction

  function automatic int fsy_f(input int img_h, input int win);
    return (img_h - 1) / (win - 1);
  endfunction

  function automatic int npix_f(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_win_addr.sv
// +----------------------------------------------------------------------------+
// | lcd_win_addr : maps view mode, anchor, row/col and mirror to buffer address |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcd_win_addr
  import lcd_win_pkg::*;
#(
  parameter int IMG_W = 12,
  parameter int IMG_H = 9,
  parameter int WIN   = 4,
  parameter int AW    = 7,
  parameter int XW    = 4,
  parameter int CW    = 2
) (
  input  logic          zoom_i,
  input  logic [XW-1:0] x_i,
  input  logic [XW-1:0] y_i,
  input  logic [CW-1:0] row_i,
  input  logic [CW-1:0] col_i,
  input  logic          mirror_i,
  output logic [AW-1:0] addr_o
);

  localparam int FSX = fsx_f(IMG_W, WIN);
  localparam int FSY = fsy_f(IMG_H, WIN);

  int r_idx;
  int c_idx;
  int addr_int;

  always_comb begin
    r_idx    = int'(row_i);
    c_idx    = mirror_i ? (WIN - 1 - int'(col_i)) : int'(col_i);
    addr_int = 0;
    // Anchor limits keep the zoom window inside the frame, so no underflow here.
    if (zoom_i) begin
      addr_int = (int'(y_i) - WIN / 2 + r_idx) * IMG_W + (int'(x_i) - WIN / 2 + c_idx);
    end else begin
      addr_int = (FSY / 2 + r_idx * FSY) * IMG_W + FSX / 2 + c_idx * FSX;
    end
    addr_o = AW'(addr_int);
  end

endmodule

`default_nettype wire

// File: rtl/lcd_win_ctrl.sv
// +----------------------------------------------------------------------------+
// | lcd_win_ctrl : frame buffer loader and fit/zoom WIN x WIN view streamer     |
// | Optional feature macro: MIRROR_EN (cmd 7 toggles horizontal mirroring)      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcd_win_ctrl
  import lcd_win_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 12,
  parameter int IMG_H = 9,
  parameter int WIN   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int N_PIX = npix_f(IMG_W, IMG_H);
  localparam int AW    = $clog2(N_PIX);
  localparam int XW    = $clog2(max_f(IMG_W, IMG_H) + 1);
  localparam int CW    = $clog2(WIN);

  localparam logic [XW-1:0] X_MIN    = XW'(WIN / 2);
  localparam logic [XW-1:0] X_MAX    = XW'(IMG_W - WIN / 2);
  localparam logic [XW-1:0] Y_MIN    = XW'(WIN / 2);
  localparam logic [XW-1:0] Y_MAX    = XW'(IMG_H - WIN / 2);
  localparam logic [XW-1:0] X_CTR    = XW'((IMG_W + 1) / 2);
  localparam logic [XW-1:0] Y_CTR    = XW'((IMG_H + 1) / 2);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_PIX - 1);
  localparam logic [CW-1:0] LAST_RC  = CW'(WIN - 1);

  state_e          state_q;
  view_mode_e      mode_q;
  logic [XW-1:0]   x_q, y_q;
  logic [CW-1:0]   row_q, col_q;
  logic [AW-1:0]   idx_q;
  logic [DW-1:0]   dataout_q;
  logic            valid_q, busy_q;
  logic [AW-1:0]   rd_addr;
  logic            mirror_on;
  logic [DW-1:0]   mem_q [N_PIX];

`ifdef MIRROR_EN
  logic mirror_q;
  assign mirror_on = mirror_q;
`else
  assign mirror_on = 1'b0;
`endif

  lcd_win_addr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN),
    .AW    (AW),
    .XW    (XW),
    .CW    (CW)
  ) u_addr (
    .zoom_i   (mode_q == VM_ZOOM),
    .x_i      (x_q),
    .y_i      (y_q),
    .row_i    (row_q),
    .col_i    (col_q),
    .mirror_i (mirror_on),
    .addr_o   (rd_addr)
  );

  // Frame buffer contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) begin
      mem_q[idx_q] <= datain;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= VM_FIT;
      x_q       <= X_CTR;
      y_q       <= Y_CTR;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MIRROR_EN
      mirror_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Entered with busy still high right after a burst; that cycle only clears it.
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          if (cmd_valid && !busy_q) begin
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            state_q <= (cmd_e'(cmd) == CMD_LOAD) ? ST_LOAD : ST_OUT;
            case (cmd_e'(cmd))
              CMD_ZOOM_IN: begin
                if (mode_q == VM_FIT) begin
                  mode_q <= VM_ZOOM;
                  x_q    <= X_CTR;
                  y_q    <= Y_CTR;
                end
              end
              CMD_ZOOM_FIT: mode_q <= VM_FIT;
              CMD_RIGHT: if (mode_q == VM_ZOOM && x_q < X_MAX) x_q <= x_q + XW'(1);
              CMD_LEFT:  if (mode_q == VM_ZOOM && x_q > X_MIN) x_q <= x_q - XW'(1);
              CMD_UP:    if (mode_q == VM_ZOOM && y_q > Y_MIN) y_q <= y_q - XW'(1);
              CMD_DOWN:  if (mode_q == VM_ZOOM && y_q < Y_MAX) y_q <= y_q + XW'(1);
`ifdef MIRROR_EN
              CMD_REFRESH: mirror_q <= ~mirror_q;
`endif
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          idx_q <= idx_q + AW'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= ST_OUT;
            mode_q  <= VM_FIT;
`ifdef MIRROR_EN
            mirror_q <= 1'b0;
`endif
          end
        end
        ST_OUT: begin
          dataout_q <= mem_q[rd_addr];
          valid_q   <= 1'b1;
          if (col_q == LAST_RC) begin
            col_q <= '0;
            if (row_q == LAST_RC) begin
              state_q <= ST_IDLE;
            end else begin
              row_q <= row_q + CW'(1);
            end
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dataout      = dataout_q;
  assign output_valid = valid_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_win_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_lcd_win_ctrl : scoreboard bench for lcd_win_ctrl (MIRROR_EN aware)       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lcd_win_ctrl;

  typedef int view_t [16];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] datain = '0;
  logic [2:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q [$];

  int  ax = 6;
  int  ay = 5;
  bit  zoom = 1'b0;

  view_t FIT_V = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
  view_t Z65_V = '{40, 41, 42, 43, 52, 53, 54, 55, 64, 65, 66, 67, 76, 77, 78, 79};
  view_t Z75_V = '{41, 42, 43, 44, 53, 54, 55, 56, 65, 66, 67, 68, 77, 78, 79, 80};
  view_t Z22_V = '{0, 1, 2, 3, 12, 13, 14, 15, 24, 25, 26, 27, 36, 37, 38, 39};
  view_t M65_V = '{43, 42, 41, 40, 55, 54, 53, 52, 67, 66, 65, 64, 79, 78, 77, 76};

  lcd_win_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .datain       (datain),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .dataout      (dataout),
    .output_valid (output_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic view_t zv(input int x, input int y);
    view_t v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[r*4+c] = (y - 2 + r) * 12 + (x - 2 + c);
    return v;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && output_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pixel: got %0d expected none", dataout);
      end else begin
        chk("pixel", int'(dataout), exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_wait", 1, 0);
  endtask

  task automatic issue(input logic [2:0] c, input view_t e, input bit pulse);
    int k, first, vcnt;
    bit is_load;
    is_load = (c == 3'd0);
    wait_idle();
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    foreach (e[i]) exp_q.push_back(e[i]);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0; first = -1; vcnt = 0;
    fork
      begin
        if (is_load) begin
          for (int i = 0; i < 108; i++) begin
            datain = 8'(i);
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        if (pulse) begin
          repeat (5) @(posedge clk);
          #1 cmd = 3'd3;
          cmd_valid = 1'b1;
          @(posedge clk);
          #1 cmd_valid = 1'b0;
        end
      end
      begin
        forever begin
          @(negedge clk);
          if (!busy || k > 400) break;
          if (output_valid) begin
            if (first < 0) first = k;
            vcnt++;
          end
          k++;
        end
      end
    join
    chk("busy_len", k, is_load ? 125 : 17);
    chk("first_lat", first, is_load ? 109 : 1);
    chk("valid_len", vcnt, 16);
    chk("valid_end", int'(output_valid), 0);
    chk("drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic shift(input logic [2:0] c);
    if (zoom) begin
      case (c)
        3'd3: if (ax < 10) ax++;
        3'd4: if (ax > 2) ax--;
        3'd5: if (ay > 2) ay--;
        3'd6: if (ay < 7) ay++;
        default: ;
      endcase
    end
    issue(c, zoom ? zv(ax, ay) : FIT_V, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dataout", int'(dataout), 0);
    chk("rst_valid", int'(output_valid), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd0, FIT_V, 1'b0);
    zoom = 1; ax = 6; ay = 5;
    issue(3'd1, Z65_V, 1'b1);
    ax = 7;
    issue(3'd3, Z75_V, 1'b0);
    issue(3'd1, Z75_V, 1'b0);

    repeat (9) shift(3'd4);
    chk("anchor_x_min", ax, 2);
    repeat (8) shift(3'd5);
    issue(3'd5, Z22_V, 1'b0);
    repeat (9) shift(3'd3);
    repeat (6) shift(3'd6);

    zoom = 0;
    issue(3'd2, FIT_V, 1'b0);
    shift(3'd3);
    zoom = 1; ax = 6; ay = 5;
    issue(3'd1, Z65_V, 1'b0);

    // Abort a reload halfway; the buffer keeps identical values.
    wait_idle();
    @(negedge clk);
    cmd = 3'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      datain = 8'(i);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(output_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    zoom = 0; ax = 6; ay = 5;
    issue(3'd2, FIT_V, 1'b0);

    zoom = 1;
    issue(3'd1, Z65_V, 1'b0);
`ifdef MIRROR_EN
    issue(3'd7, M65_V, 1'b0);
    issue(3'd7, Z65_V, 1'b0);
    issue(3'd7, M65_V, 1'b0);
`else
    issue(3'd7, Z65_V, 1'b0);
    issue(3'd7, Z65_V, 1'b0);
    issue(3'd7, Z65_V, 1'b0);
`endif
    zoom = 0;
    issue(3'd0, FIT_V, 1'b0);
    zoom = 1;
    issue(3'd1, Z65_V, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
